regfile_write_arbiter: RTL and testbench

Shares the single write port of the 16 x 32-bit register file among up to four writeback requesters (ALU, load unit, multiplier, CSR path). Each cycle it grants at most one valid request using round-robin priority and drives the register file's load enable, 4-bit destination and 32-bit data from a registered stage, so the register file's binary decoder sees clean, glitch-free inputs. It sits between the writeback sources and the register file and contains no storage beyond one write stage and the priority pointer.

---
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port among
//            up to four writeback sources, with one registered write stage.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              wr_stall,
  output logic              wr_ld,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [1:0]        wr_src
);

  logic [1:0]    r_ptr;
  logic [3:0]    w_vpad;
  logic [3:0]    w_gnt4;
  logic [1:0]    w_gidx;
  logic          w_any;
  logic [2:0]    w_scan;
  logic [2:0]    w_pnext;
  logic          w_xfer;
  logic [AW-1:0] w_gaddr;
  logic [DW-1:0] w_gdata;

  assign w_vpad = 4'(req_valid);

  // Scan from r_ptr upward, wrapping at NREQ; the first valid index wins.
  always_comb begin
    w_gnt4 = 4'b0000;
    w_gidx = 2'd0;
    w_any  = 1'b0;
    w_scan = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = 3'(r_ptr) + 3'(k);
      if (w_scan >= 3'(NREQ)) begin
        w_scan = w_scan - 3'(NREQ);
      end
      if (!w_any && w_vpad[w_scan[1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_scan[1:0];
        w_gnt4[w_scan[1:0]] = 1'b1;
      end
    end
  end

  assign w_xfer    = w_any && !wr_stall && !reset;
  assign req_ready = (wr_stall || reset) ? '0 : w_gnt4[NREQ-1:0];

  assign w_gaddr = req_addr[int'(w_gidx)*AW +: AW];
  assign w_gdata = req_data[int'(w_gidx)*DW +: DW];

  always_comb begin
    w_pnext = 3'(w_gidx) + 3'd1;
    if (w_pnext >= 3'(NREQ)) begin
      w_pnext = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= 2'd0;
      wr_ld   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 2'd0;
    end else begin
      wr_ld <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= w_pnext[1:0];
        wr_addr <= w_gaddr;
        wr_data <= w_gdata;
        wr_src  <= w_gidx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_stall;
  logic              wr_ld;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_src;

  int n_tests;
  int n_fail;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_ld     (wr_ld),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic chk_wr(input string tag, input logic ld, input logic [1:0] src,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".ld"},   32'(wr_ld),   32'(ld));
    chk({tag, ".src"},  32'(wr_src),  32'(src));
    chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
    chk({tag, ".data"}, wr_data, d);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    wr_stall  = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 8), 32'hD000_0000 | 32'(i));

    // Reset held two cycles with every requester valid
    tick();
    chk("rst_ready0", 32'(req_ready), 32'h0);
    tick();
    chk("rst_ready1", 32'(req_ready), 32'h0);
    chk_wr("rst", 1'b0, 2'd0, 4'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Single requester 2
    set_req(2, 4'd5, 32'hAABB_AABB);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk_wr("single", 1'b1, 2'd2, 4'd5, 32'hAABB_AABB);
    tick();
    chk_wr("single_idle", 1'b0, 2'd2, 4'd5, 32'hAABB_AABB);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 8), 32'hD000_0000 | 32'(i));
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      tick();
      chk_wr($sformatf("rr%0d", c), 1'b1, 2'(c % 4), AW'((c % 4) + 8),
             32'hD000_0000 | 32'(c % 4));
    end
    req_valid = '0;
    tick();

    // Skip pattern: move ptr to 1, then only 0 and 3 valid
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1001;
    #1;
    chk("skip_ready3", 32'(req_ready), 32'h8);
    tick();
    chk_wr("skip3", 1'b1, 2'd3, 4'd11, 32'hD000_0003);
    chk("skip_ready0", 32'(req_ready), 32'h1);
    tick();
    chk_wr("skip0", 1'b1, 2'd0, 4'd8, 32'hD000_0000);
    req_valid = '1;
    #1;
    chk("skip_ptr1", 32'(req_ready), 32'h2);

    // Stall mid-stream: grant 1, then stall three cycles
    tick();
    wr_stall = 1'b1;
    #1;
    chk("stall_ready_in", 32'(req_ready), 32'h0);
    chk_wr("stall_staged", 1'b1, 2'd1, 4'd9, 32'hD000_0001);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall_ready%0d", c), 32'(req_ready), 32'h0);
      chk($sformatf("stall_ld%0d", c), 32'(wr_ld), 32'h0);
    end
    wr_stall = 1'b0;
    #1;
    chk("resume_ready", 32'(req_ready), 32'h4);
    tick();
    chk_wr("resume", 1'b1, 2'd2, 4'd10, 32'hD000_0002);

    // Reset right after a transfer drops the staged write
    tick();
    chk_wr("pre_rst", 1'b1, 2'd3, 4'd11, 32'hD000_0003);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    chk_wr("midrst", 1'b0, 2'd0, 4'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk_wr("post_rst", 1'b1, 2'd0, 4'd8, 32'hD000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
